keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 92 +++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad row by row, debounces press and release,
// and reports one accepted key at a time as row*4+col with a single-cycle valid pulse.
module keypad_scanner #(
    parameter logic [21:0] SCAN_DIVIDER     = 22'd50000,
    parameter logic [21:0] DEBOUNCE_DIVIDER = 22'd2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    state_t      r_state, w_next;
    logic [21:0] r_cnt, w_cnt_next;
    logic [1:0]  r_row, w_row_next, r_col, w_col_next, w_low_col;
    logic [3:0]  r_sync, r_cs, r_code;
    logic        r_valid, w_any, w_col_high, w_scan_end, w_deb_end;
    assign w_any      = ~&r_cs;
    assign w_low_col  = !r_cs[0] ? 2'd0 : !r_cs[1] ? 2'd1 : !r_cs[2] ? 2'd2 : 2'd3;
    assign w_col_high = r_cs[r_col];
    assign w_scan_end = r_cnt == SCAN_DIVIDER - 22'd1;
    assign w_deb_end  = r_cnt == DEBOUNCE_DIVIDER - 22'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCAN;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
            r_cnt   <= 22'd0;
            r_sync  <= 4'hf;
            r_cs    <= 4'hf;
            r_code  <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            r_cnt   <= w_cnt_next;
            r_sync  <= cols;
            r_cs    <= r_sync;
            r_valid <= r_state == DEBOUNCE && w_next == HELD;
            if (r_state == DEBOUNCE && w_next == HELD)
                r_code <= {r_row, r_col};
        end
    end
    // Counter restarts on every state or row change; HELD has no timeout so it parks at 0.
    always_comb begin
        w_next     = r_state;
        w_row_next = r_row;
        w_col_next = r_col;
        w_cnt_next = r_cnt + 22'd1;
        case (r_state)
            SCAN: if (w_scan_end) begin
                w_cnt_next = 22'd0;
                if (w_any) begin
                    w_next     = DEBOUNCE;
                    w_col_next = w_low_col;
                end else
                    w_row_next = r_row + 2'd1;
            end
            DEBOUNCE: if (w_col_high) begin
                w_next     = SCAN;
                w_row_next = r_row + 2'd1;
                w_cnt_next = 22'd0;
            end else if (w_deb_end) begin
                w_next     = HELD;
                w_cnt_next = 22'd0;
            end
            HELD: begin
                w_cnt_next = 22'd0;
                if (w_col_high)
                    w_next = RELEASE;
            end
            RELEASE: if (!w_col_high) begin
                w_next     = HELD;
                w_cnt_next = 22'd0;
            end else if (w_deb_end) begin
                w_next     = SCAN;
                w_row_next = r_row + 2'd1;
                w_cnt_next = 22'd0;
            end
        endcase
    end
    always_comb begin
        rows      = ~(4'b0001 << r_row);
        key_held  = r_state == HELD || r_state == RELEASE;
        key_valid = r_valid;
        key_code  = r_code;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad into keypad_scanner and checks
// accepted keys against expectations derived from the keypad contents.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cols, rows, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = 16'h0;
    int          checks = 0;
    int          failures = 0;
    int          inv_viol = 0;
    logic        prev_valid = 1'b0;

    keypad_scanner #(.SCAN_DIVIDER(22'd4), .DEBOUNCE_DIVIDER(22'd10)) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven low.
    always_comb begin
        cols = 4'hf;
        for (int r = 0; r < 4; r++)
            if (!rows[r]) cols = cols & ~keys[r*4 +: 4];
    end

    always @(negedge clk) begin
        if (!$isunknown(rows) && $countones(~rows) != 1) inv_viol++;
        if (key_valid === 1'b1 && prev_valid === 1'b1) inv_viol++;
        prev_valid = key_valid;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc;
        cyc;
        reset = 1'b0;
    endtask

    task automatic watch(input int n, output int np, output logic [3:0] code, output int first);
        np = 0;
        code = 4'h0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            cyc;
            if (key_valid === 1'b1) begin
                np++;
                code = key_code;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic test_reset;
        keys = 16'h0;
        reset = 1'b1;
        cyc;
        cyc;
        checks += 4;
        if (rows !== 4'b1110) begin failures++; $display("FAIL reset_rows got=%b exp=1110", rows); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
        if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", key_code); end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        logic [3:0] exp;
        keys = 16'h0;
        do_reset;
        for (int k = 0; k < 40; k++) begin
            exp = ~(4'b0001 << ((k / 4) % 4));
            checks += 2;
            if (rows !== exp) begin failures++; $display("FAIL idle_rows k=%0d got=%b exp=%b", k, rows, exp); end
            if (key_valid !== 1'b0) begin failures++; $display("FAIL idle_valid k=%0d got=%b exp=0", k, key_valid); end
            cyc;
        end
    endtask

    // Release ends 10 stable cycles after the 2-cycle synchronizer sees it; scan resumes at row 3.
    task automatic final_release(input string tag);
        keys = 16'h0;
        for (int e = 1; e <= 14; e++) begin
            cyc;
            checks++;
            if (key_valid !== 1'b0) begin failures++; $display("FAIL %s_rel_valid e=%0d got=%b exp=0", tag, e, key_valid); end
            if (e == 11) begin
                checks++;
                if (key_held !== 1'b1) begin failures++; $display("FAIL %s_held_early got=%b exp=1", tag, key_held); end
            end
            if (e == 14) begin
                checks += 2;
                if (key_held !== 1'b0) begin failures++; $display("FAIL %s_held_late got=%b exp=0", tag, key_held); end
                if (rows !== 4'b0111) begin failures++; $display("FAIL %s_resume_row got=%b exp=0111", tag, rows); end
            end
        end
    endtask

    task automatic test_clean_press;
        int np, first;
        logic [3:0] code;
        do_reset;
        keys = 16'h0200;
        watch(60, np, code, first);
        checks += 3;
        if (np != 1) begin failures++; $display("FAIL clean_pulses got=%0d exp=1", np); end
        if (code !== 4'h9) begin failures++; $display("FAIL clean_code got=%h exp=9", code); end
        if (key_held !== 1'b1) begin failures++; $display("FAIL clean_held got=%b exp=1", key_held); end
        final_release("clean");
    endtask

    task automatic test_press_bounce;
        int np, first, w;
        logic [3:0] code;
        do_reset;
        w = 0;
        while (rows !== 4'b1011 && w < 40) begin cyc; w++; end
        checks++;
        if (rows !== 4'b1011) begin failures++; $display("FAIL bounce_row_wait got=%b exp=1011", rows); end
        for (int i = 0; i < 8; i++) begin
            keys[9] = ~keys[9];
            for (int j = 0; j < 3; j++) begin
                cyc;
                checks++;
                if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_early_valid i=%0d got=%b exp=0", i, key_valid); end
            end
        end
        keys = 16'h0200;
        watch(60, np, code, first);
        checks += 3;
        if (np != 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", np); end
        if (code !== 4'h9) begin failures++; $display("FAIL bounce_code got=%h exp=9", code); end
        if (first < 11) begin failures++; $display("FAIL bounce_stable got=%0d exp>=11", first); end
        keys = 16'h0;
        watch(30, np, code, first);
    endtask

    task automatic test_release_bounce;
        int np, first;
        logic [3:0] code;
        do_reset;
        keys = 16'h0200;
        watch(60, np, code, first);
        checks += 2;
        if (np != 1) begin failures++; $display("FAIL relb_pulses got=%0d exp=1", np); end
        if (code !== 4'h9) begin failures++; $display("FAIL relb_code got=%h exp=9", code); end
        for (int i = 0; i < 15; i++) begin
            keys = (i < 5) ? 16'h0 : 16'h0200;
            cyc;
            checks += 2;
            if (key_held !== 1'b1) begin failures++; $display("FAIL relb_glitch_held i=%0d got=%b exp=1", i, key_held); end
            if (key_valid !== 1'b0) begin failures++; $display("FAIL relb_glitch_valid i=%0d got=%b exp=0", i, key_valid); end
        end
        final_release("relb");
    endtask

    task automatic test_multi_key;
        int np, first;
        logic [3:0] code;
        do_reset;
        keys = 16'h1001;
        watch(60, np, code, first);
        checks += 4;
        if (np != 1) begin failures++; $display("FAIL multi_pulses got=%0d exp=1", np); end
        if (code !== 4'h0) begin failures++; $display("FAIL multi_code got=%h exp=0", code); end
        if (rows !== 4'b1110) begin failures++; $display("FAIL multi_rows got=%b exp=1110", rows); end
        if (key_held !== 1'b1) begin failures++; $display("FAIL multi_held got=%b exp=1", key_held); end
        keys = 16'h0;
        watch(30, np, code, first);
    endtask

    task automatic test_reset_debounce;
        int np, first;
        logic [3:0] code;
        do_reset;
        keys = 16'h0020;
        repeat (13) cyc;
        checks += 2;
        if (rows !== 4'b1101) begin failures++; $display("FAIL rstdb_row got=%b exp=1101", rows); end
        if (key_held !== 1'b0) begin failures++; $display("FAIL rstdb_pre_held got=%b exp=0", key_held); end
        reset = 1'b1;
        cyc;
        checks += 4;
        if (rows !== 4'b1110) begin failures++; $display("FAIL rstdb_rows got=%b exp=1110", rows); end
        if (key_held !== 1'b0) begin failures++; $display("FAIL rstdb_held got=%b exp=0", key_held); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL rstdb_valid got=%b exp=0", key_valid); end
        if (key_code !== 4'h0) begin failures++; $display("FAIL rstdb_code got=%h exp=0", key_code); end
        keys = 16'h0;
        reset = 1'b0;
        watch(30, np, code, first);
        checks++;
        if (np != 0) begin failures++; $display("FAIL rstdb_after_pulses got=%0d exp=0", np); end
    endtask

    task automatic test_random;
        int np, first, row, expc;
        logic [3:0] mask, code;
        do_reset;
        for (int it = 0; it < 10; it++) begin
            row  = $urandom_range(0, 3);
            mask = 4'($urandom_range(1, 15));
            expc = -1;
            for (int c = 3; c >= 0; c--) if (mask[c]) expc = row * 4 + c;
            keys = 16'h0;
            keys[row*4 +: 4] = mask;
            watch(60, np, code, first);
            checks += 2;
            if (np != 1) begin failures++; $display("FAIL rand_pulses it=%0d got=%0d exp=1", it, np); end
            if (code !== 4'(expc)) begin failures++; $display("FAIL rand_code it=%0d got=%h exp=%h", it, code, 4'(expc)); end
            keys = 16'h0;
            watch(30, np, code, first);
            checks++;
            if (np != 0) begin failures++; $display("FAIL rand_release_pulses it=%0d got=%0d exp=0", it, np); end
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (inv_viol != 0) begin failures++; $display("FAIL invariants got=%0d exp=0", inv_viol); end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_clean_press;
        test_press_bounce;
        test_release_bounce;
        test_multi_key;
        test_reset_debounce;
        test_random;
        test_invariants;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
